// File: rtl/ps2_mouse_tracker.sv
// Receive-only PS/2 mouse front end: pin conditioning, frame deframing,
// packet assembly and clamped cursor tracking for the display path.
module ps2_mouse_tracker #(
  parameter int unsigned POS_W   = 16,
  parameter int unsigned X_MAX   = 639,
  parameter int unsigned Y_MAX   = 479,
  parameter int unsigned WHEEL   = 0,
  parameter int unsigned FILT    = 4,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  output logic [POS_W-1:0] pos_x,
  output logic [POS_W-1:0] pos_y,
  output logic [2:0]       buttons,
  output logic [3:0]       wheel,
  output logic             pkt_valid,
  output logic             err
);

  localparam int unsigned SW = POS_W + 2;
  localparam int unsigned FW = (FILT > 1) ? $clog2(FILT) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] LAST = 2'(2 + WHEEL);
  localparam logic signed [SW-1:0] XMAX_S = SW'(X_MAX);
  localparam logic signed [SW-1:0] YMAX_S = SW'(Y_MAX);

  typedef enum logic [1:0] {
    F_IDLE,
    F_DATA,
    F_PARITY,
    F_STOP
  } fstate_t;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt_clk;
  logic [FW-1:0] filt_cnt;
  logic          fall;
  logic          samp;

  fstate_t       fstate;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_ok;
  logic          byte_stb;
  logic          frame_err;

  logic [TW-1:0] to_cnt;
  logic          active;
  logic          timeout_c;

  logic [1:0]    idx;
  logic [6:0]    hdr;  // {y_ovf, x_ovf, y_sign, x_sign, middle, right, left}
  logic [7:0]    b1;
  logic [7:0]    b2;

  logic [7:0]           fin_y;
  logic signed [8:0]    dx, dy;
  logic signed [SW-1:0] sum_x, dif_y;
  logic [POS_W-1:0]     nx, ny;

  // Two-stage synchronisers on both PS/2 pins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // Glitch filter on ps2_clk; a filtered falling edge captures the data bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
      samp     <= 1'b1;
    end else begin
      fall <= 1'b0;
      if (clk_s2 == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILT - 1)) begin
        filt_clk <= clk_s2;
        filt_cnt <= '0;
        if (!clk_s2) begin
          fall <= 1'b1;
          samp <= dat_s2;
        end
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  // Idle watchdog: only armed while a frame or packet is partially received
  assign active = (fstate != F_IDLE) || (idx != 2'd0);

  always_comb begin
    timeout_c = active && !fall && (to_cnt == TW'(TIMEOUT - 1));
  end

  // Watchdog counter, cleared by any device clock activity
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt <= '0;
    end else if (fall || !active || timeout_c) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + TW'(1);
    end
  end

  // Frame FSM: start, 8 data bits LSB first, odd parity, stop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fstate    <= F_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_ok    <= 1'b0;
      byte_stb  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      byte_stb  <= 1'b0;
      frame_err <= 1'b0;
      if (timeout_c) begin
        fstate <= F_IDLE;
      end else if (fall) begin
        case (fstate)
          F_IDLE: begin
            if (!samp) begin
              fstate  <= F_DATA;
              bit_cnt <= '0;
            end
          end
          F_DATA: begin
            shreg   <= {samp, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) fstate <= F_PARITY;
          end
          F_PARITY: begin
            par_ok <= ^{shreg, samp};
            fstate <= F_STOP;
          end
          F_STOP: begin
            fstate <= F_IDLE;
            if (samp && par_ok) byte_stb <= 1'b1;
            else frame_err <= 1'b1;
          end
          default: fstate <= F_IDLE;
        endcase
      end
    end
  end

  // Movement deltas and clamped next cursor position for the final byte
  always_comb begin
    fin_y = (WHEEL != 0) ? b2 : shreg;
    dx    = hdr[5] ? 9'sd0 : {hdr[3], b1};
    dy    = hdr[6] ? 9'sd0 : {hdr[4], fin_y};
    sum_x = SW'(pos_x) + {{(SW - 9){dx[8]}}, dx};
    dif_y = SW'(pos_y) - {{(SW - 9){dy[8]}}, dy};
    if (sum_x[SW-1])        nx = '0;
    else if (sum_x > XMAX_S) nx = POS_W'(X_MAX);
    else                     nx = sum_x[POS_W-1:0];
    if (dif_y[SW-1])        ny = '0;
    else if (dif_y > YMAX_S) ny = POS_W'(Y_MAX);
    else                     ny = dif_y[POS_W-1:0];
  end

  // Packet assembler, header resync, cursor update and strobes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx       <= '0;
      hdr       <= '0;
      b1        <= '0;
      b2        <= '0;
      pos_x     <= POS_W'(X_MAX / 2);
      pos_y     <= POS_W'(Y_MAX / 2);
      buttons   <= '0;
      wheel     <= '0;
      pkt_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      pkt_valid <= 1'b0;
      err       <= 1'b0;
      if (timeout_c || frame_err) begin
        idx <= '0;
        err <= 1'b1;
      end else if (byte_stb) begin
        if (idx == LAST) begin
          pos_x     <= nx;
          pos_y     <= ny;
          buttons   <= hdr[2:0];
          wheel     <= (WHEEL != 0) ? shreg[3:0] : 4'h0;
          pkt_valid <= 1'b1;
          idx       <= '0;
        end else begin
          case (idx)
            2'd0: begin
              if (!shreg[3]) begin
                err <= 1'b1;
              end else begin
                hdr <= {shreg[7:4], shreg[2:0]};
                idx <= 2'd1;
              end
            end
            2'd1: begin
              b1  <= shreg;
              idx <= 2'd2;
            end
            default: begin
              b2  <= shreg;
              idx <= 2'd3;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Bench for ps2_mouse_tracker: a 3-byte and a 4-byte instance driven by a
// PS/2 device model, checked against an integer cursor model.
module tb_ps2_mouse_tracker;

  localparam int TO = 1000;
  localparam int H  = 12;
  localparam int G  = 30;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pclk, pdat;
  logic [15:0] x0, y0, x1, y1;
  logic [2:0]  bt0, bt1;
  logic [3:0]  wh0, wh1;
  logic        pv0, pv1, er0, er1;

  int errors = 0;
  int checks = 0;
  int npkt0 = 0, npkt1 = 0, nerr0 = 0, nerr1 = 0, nboth = 0;

  int         mx[2], my[2], ep[2], ee[2];
  logic [2:0] mb[2];
  logic [3:0] mw[2];

  always #5 clk = ~clk;

  ps2_mouse_tracker #(.WHEEL(0), .FILT(4), .TIMEOUT(TO)) dut0 (
    .clk(clk), .rst(rst), .ps2_clk(pclk[0]), .ps2_data(pdat[0]),
    .pos_x(x0), .pos_y(y0), .buttons(bt0), .wheel(wh0),
    .pkt_valid(pv0), .err(er0)
  );

  ps2_mouse_tracker #(.WHEEL(1), .FILT(4), .TIMEOUT(TO)) dut1 (
    .clk(clk), .rst(rst), .ps2_clk(pclk[1]), .ps2_data(pdat[1]),
    .pos_x(x1), .pos_y(y1), .buttons(bt1), .wheel(wh1),
    .pkt_valid(pv1), .err(er1)
  );

  // Strobe counters
  always @(posedge clk) begin
    if (pv0 === 1'b1) npkt0++;
    if (pv1 === 1'b1) npkt1++;
    if (er0 === 1'b1) nerr0++;
    if (er1 === 1'b1) nerr1++;
    if ((pv0 === 1'b1 && er0 === 1'b1) || (pv1 === 1'b1 && er1 === 1'b1)) nboth++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_apply(input int w, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
    int dx, dy;
    dx = b0[6] ? 0 : (b0[4] ? int'(b1) - 256 : int'(b1));
    dy = b0[7] ? 0 : (b0[5] ? int'(b2) - 256 : int'(b2));
    mx[w] = clampi(mx[w] + dx, 639);
    my[w] = clampi(my[w] - dy, 479);
    mb[w] = b0[2:0];
    mw[w] = (w == 1) ? b3[3:0] : 4'h0;
    ep[w]++;
  endtask

  task automatic check_dut(input int w, input string tag);
    if (w == 0) begin
      chk({tag, " x0"}, 32'(x0), mx[0]);
      chk({tag, " y0"}, 32'(y0), my[0]);
      chk({tag, " btn0"}, 32'(bt0), 32'(mb[0]));
      chk({tag, " wheel0"}, 32'(wh0), 32'(mw[0]));
      chk({tag, " pkts0"}, npkt0, ep[0]);
      chk({tag, " errs0"}, nerr0, ee[0]);
    end else begin
      chk({tag, " x1"}, 32'(x1), mx[1]);
      chk({tag, " y1"}, 32'(y1), my[1]);
      chk({tag, " btn1"}, 32'(bt1), 32'(mb[1]));
      chk({tag, " wheel1"}, 32'(wh1), 32'(mw[1]));
      chk({tag, " pkts1"}, npkt1, ep[1]);
      chk({tag, " errs1"}, nerr1, ee[1]);
    end
  endtask

  task automatic drive_bits(input int w, input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) pdat[w] = f[i];
      repeat (H) @(negedge clk);
      pclk[w] = 1'b0;
      repeat (H) @(negedge clk);
      pclk[w] = 1'b1;
    end
    pdat[w] = 1'b1;
    repeat (G) @(negedge clk);
  endtask

  task automatic send_byte(input int w, input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic p;
    logic [10:0] f;
    p = ~(^b) ^ bad_par;
    f = {~bad_stop, p, b, 1'b0};
    drive_bits(w, f, 11);
  endtask

  task automatic send_pkt(input int w, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3);
    send_byte(w, b0, 1'b0, 1'b0);
    send_byte(w, b1, 1'b0, 1'b0);
    send_byte(w, b2, 1'b0, 1'b0);
    if (w == 1) send_byte(w, b3, 1'b0, 1'b0);
    model_apply(w, b0, b1, b2, b3);
  endtask

  initial begin
    logic [7:0] r0, r1, r2, r3;
    rst  = 1'b0;
    pclk = 2'b11;
    pdat = 2'b11;
    for (int w = 0; w < 2; w++) begin
      mx[w] = 319; my[w] = 239; mb[w] = 3'b000; mw[w] = 4'h0; ep[w] = 0; ee[w] = 0;
    end
    repeat (5) @(negedge clk);
    chk("reset x0", 32'(x0), 319);
    chk("reset y0", 32'(y0), 239);
    chk("reset btn0", 32'(bt0), 0);
    chk("reset pv0", 32'(pv0), 0);
    chk("reset err0", 32'(er0), 0);
    chk("reset x1", 32'(x1), 319);
    chk("reset wheel1", 32'(wh1), 0);
    rst = 1'b1;
    repeat (2 * TO) @(negedge clk);
    check_dut(0, "idle");
    check_dut(1, "idle");

    // Basic packet
    send_pkt(0, 8'h09, 8'h0A, 8'h05, 8'h00);
    chk("pkt1 x0", 32'(x0), 329);
    chk("pkt1 y0", 32'(y0), 234);
    chk("pkt1 btn0", 32'(bt0), 1);
    check_dut(0, "pkt1");

    // Bad parity on the second byte aborts the packet
    send_byte(0, 8'h08, 1'b0, 1'b0);
    send_byte(0, 8'h01, 1'b1, 1'b0);
    ee[0]++;
    check_dut(0, "badpar");
    send_pkt(0, 8'h08, 8'h01, 8'h00, 8'h00);
    chk("after badpar x0", 32'(x0), 330);
    check_dut(0, "after badpar");

    // Header without bit3 is discarded
    send_byte(0, 8'h00, 1'b0, 1'b0);
    ee[0]++;
    check_dut(0, "resync");
    send_pkt(0, 8'h0A, 8'h02, 8'h00, 8'h00);
    check_dut(0, "after resync");

    // Bad stop bit
    send_byte(0, 8'h09, 1'b0, 1'b0);
    send_byte(0, 8'h05, 1'b0, 1'b1);
    ee[0]++;
    check_dut(0, "badstop");

    // Partial frame then silence
    drive_bits(0, 11'h000, 4);
    repeat (TO) @(negedge clk);
    ee[0]++;
    check_dut(0, "frame timeout");
    send_pkt(0, 8'h0C, 8'h03, 8'h04, 8'h00);
    check_dut(0, "after ftimeout");

    // Clamp to left edge, then to right edge
    send_pkt(0, 8'h18, 8'h00, 8'h00, 8'h00);
    send_pkt(0, 8'h18, 8'h00, 8'h00, 8'h00);
    chk("clamp left x0", 32'(x0), 0);
    for (int i = 0; i < 6; i++) send_pkt(0, 8'h08, 8'h7F, 8'h00, 8'h00);
    chk("clamp right x0", 32'(x0), 639);
    check_dut(0, "clampx");

    // Clamp y to bottom and top
    for (int i = 0; i < 4; i++) send_pkt(0, 8'h28, 8'h00, 8'h80, 8'h00);
    chk("clamp bottom y0", 32'(y0), 479);
    for (int i = 0; i < 4; i++) send_pkt(0, 8'h08, 8'h00, 8'h7F, 8'h00);
    chk("clamp top y0", 32'(y0), 0);

    // Overflow bits zero the axis but buttons still update
    send_pkt(0, 8'h4E, 8'h10, 8'h90, 8'h00);
    check_dut(0, "xovf");
    send_pkt(0, 8'h8D, 8'hF0, 8'h10, 8'h00);
    check_dut(0, "yovf");

    // Random packets on the 3-byte instance
    for (int i = 0; i < 12; i++) begin
      r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom);
      r0[3] = 1'b1;
      if ($urandom_range(0, 5) != 0) r0[7:6] = 2'b00;
      send_pkt(0, r0, r1, r2, 8'h00);
      check_dut(0, "rand0");
    end

    // Wheel instance
    send_pkt(1, 8'h08, 8'h00, 8'h00, 8'h0F);
    chk("wheel -1", 32'(wh1), 15);
    check_dut(1, "wheel");
    send_byte(1, 8'h08, 1'b0, 1'b0);
    send_byte(1, 8'h05, 1'b0, 1'b0);
    repeat (TO + 50) @(negedge clk);
    ee[1]++;
    check_dut(1, "pkt timeout");
    send_pkt(1, 8'h0A, 8'h03, 8'hFD, 8'h01);
    check_dut(1, "after ptimeout");
    for (int i = 0; i < 6; i++) begin
      r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom); r3 = 8'($urandom);
      r0[3] = 1'b1;
      if ($urandom_range(0, 5) != 0) r0[7:6] = 2'b00;
      send_pkt(1, r0, r1, r2, r3);
      check_dut(1, "rand1");
    end
    check_dut(0, "final");

    chk("strobe overlap", nboth, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_mouse_tracker.md
# ps2_mouse_tracker

Parametrised receive-only PS/2 mouse front end that replaces the fixed mouse base module feeding the VGA cursor path. It synchronises and filters the PS/2 lines, deframes 11-bit device frames with parity/stop checking and timeout recovery, and assembles 3-byte (standard) or 4-byte (wheel) packets. It accumulates clamped cursor coordinates for a configurable screen size and reports buttons, wheel delta and packet/error strobes to the display and CPU sides.

## Interface
- POS_W, 16, width of pos_x/pos_y
- X_MAX, 639, maximum x coordinate (inclusive)
- Y_MAX, 479, maximum y coordinate (inclusive)
- WHEEL, 0, 0 = 3-byte packets, 1 = 4-byte packets (IntelliMouse)
- FILT, 4, consecutive equal samples required to accept a ps2_clk level
- TIMEOUT, 50000, idle clk cycles that abort a partial frame or packet
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- ps2_clk  in  1  PS/2 clock pin (device driven)
- ps2_data  in  1  PS/2 data pin
- pos_x  out  POS_W  cursor x, 0..X_MAX
- pos_y  out  POS_W  cursor y, 0..Y_MAX, 0 = top
- buttons  out  3  {middle, right, left}, latched from last good packet
- wheel  out  4  signed wheel delta of last packet (0 when WHEEL=0)
- pkt_valid  out  1  one-cycle strobe, new packet applied
- err  out  1  one-cycle strobe, frame/packet error or timeout

## Operation
- Input path: 2-FF synchroniser on both pins; ps2_clk filter changes state only after FILT consecutive equal synchronised samples; falling edge of filtered clock samples synchronised data.
- Frame FSM: IDLE -> DATA (8 bits, LSB first) -> PARITY -> STOP -> IDLE.
  - IDLE: sampled 0 = start bit, go DATA; sampled 1 ignored, no error.
  - PARITY: odd parity over 8 data bits plus parity bit; mismatch flagged, frame still runs to STOP.
  - STOP: sampled bit must be 1. Good frame delivers byte to assembler; parity or stop failure pulses err, drops byte, resets packet index to 0.
- Packet assembler, index 0..N-1 (N = 3 + WHEEL):
  - Byte 0 must have bit3 = 1; otherwise discarded, err pulsed, index stays 0 (resync).
  - Byte 0: bit0 L, bit1 R, bit2 M, bit4 X sign, bit5 Y sign, bit6 X ovf, bit7 Y ovf.
  - dx = signed 9-bit {Xsign, byte1}; dy = {Ysign, byte2}; wheel = byte3[3:0].
  - Axis with ovf set uses delta 0; buttons still update.
- Update on final byte: new_x = pos_x + dx; new_y = pos_y - dy (PS/2 up-positive, screen down-positive). Arithmetic in POS_W+2 signed bits; result < 0 clamps to 0, > max clamps to X_MAX/Y_MAX.
- Timeout: counter clears on every filtered falling edge; counts while frame FSM not IDLE or packet index != 0. Reaching TIMEOUT: FSM -> IDLE, index -> 0, err pulsed. Edge and timeout in same cycle: edge wins.

## Timing
- Reset (rst low, async): pos_x = X_MAX/2 (319), pos_y = Y_MAX/2 (239), buttons = 0, wheel = 0, pkt_valid = 0, err = 0, FSM IDLE, index 0, counters 0. Reset mid-frame discards partial frame/packet.
- Pin edge to internal edge detect: 2 + FILT clk cycles.
- pkt_valid high exactly one cycle, cycle after final stop bit sampled; pos_x, pos_y, buttons, wheel update at that same edge and hold until next packet.
- err is one cycle per event; never coincident with pkt_valid.
- Minimum sustainable ps2_clk half-period: FILT + 3 clk cycles.

## Test plan
- Reset release, no traffic -> pos_x = 319, pos_y = 239, buttons = 0, no strobes for 2*TIMEOUT cycles.
- Packet 0x09, 0x0A, 0x05 -> one pkt_valid, pos_x = 329, pos_y = 234, buttons = 3'b001.
- Packet 0x18, 0x00 (dx = -256) repeated twice, byte2 0x00 -> pos_x clamps to 0; 0x08, 0x7F, 0x00 x6 -> pos_x clamps to 639.
- Byte with bad parity mid-packet, then valid packet 0x08, 0x01, 0x00 -> err once, then pkt_valid, pos_x = previous + 1.
- First byte 0x00 (bit3 = 0) then valid packet -> err once, resync, one pkt_valid.
- WHEEL = 1, packet 0x08, 0x00, 0x00, 0x0F -> wheel = -1; 2 bytes then silence for TIMEOUT -> err, next 4-byte packet accepted.
